sobel_window_gen: RTL and testbench
===================================

# sobel_window_gen

Raster-scan 3x3 window generator that produces the `p0..p8` neighbourhood and `valid_in` strobe consumed by the Sobel gradient/magnitude stage. It accepts one pixel per qualified cycle and buffers the two previous image rows. It emits one fully interior 3x3 window per accepted pixel once two rows and two columns have been seen. There is no backpressure, because the downstream gradient stage is always ready.

## Interface
- `IMG_W`, 640: pixels per line. Must be ≥ 3.
- `IMG_H`, 480: lines per frame. Must be ≥ 3.
- `clk`  in  1: single clock. All logic is rising-edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `pix_valid`  in  1: `pix_in` is accepted this cycle.
- `pix_sof`  in  1: qualified by `pix_valid`. The accepted pixel is pixel (0,0) of a new frame.
- `pix_in`  in  8: unsigned greyscale pixel.
- `valid_out`  out  1: `p0..p8` hold a new window this cycle. Drives the gradient stage's `valid_in`.
- `p0,p1,p2`  out  8 each: top row (row r-2), columns c-2, c-1, c.
- `p3,p4,p5`  out  8 each: middle row (r-1), same columns.
- `p6,p7,p8`  out  8 each: bottom row (r), same columns. `p8` is the newest pixel.
- `eof_out`  out  1: coincides with `valid_out` for the last window of a frame.

## Operation
- Counters:
  - `col` (width $clog2(IMG_W)) and `row` (width $clog2(IMG_H)) give the position of the next pixel to accept.
  - Both advance only on `pix_valid`.
  - `col` wraps at IMG_W-1 and increments `row`.
  - `row` wraps at IMG_H-1 to 0, so back-to-back frames need no `pix_sof`.
- `pix_sof` with `pix_valid` forces the accepted pixel to position (0,0), regardless of counter state. The counters then become col=1, row=0. A frame in progress is abandoned silently, and no window is emitted for the abandoned frame.
- Line buffers:
  - `lb_a` holds row r-1 and `lb_b` holds row r-2. Each has IMG_W×8 bits, asynchronous read and synchronous write.
  - On accept at column c: new column = {`lb_b[c]`, `lb_a[c]`, `pix_in`}. Then `lb_b[c]` ← `lb_a[c]` and `lb_a[c]` ← `pix_in`.
  - Line-buffer contents are never reset. Stale data is masked by the row gating.
- Window registers: on accept, columns shift left. `p0/p3/p6` ← `p1/p4/p7`, `p1/p4/p7` ← `p2/p5/p8`, `p2/p5/p8` ← new column.
- FSM, states FILL and STREAM:
  - FILL: accepting rows 0–1. No output. Goes to STREAM when a pixel is accepted at (IMG_W-1, 1).
  - STREAM: `valid_out` is set on the accept edge iff col ≥ 2. Goes to FILL when the pixel at (IMG_W-1, IMG_H-1) is accepted, or on any `pix_sof` accept.
- `eof_out` is set with `valid_out` when the accepted pixel is (IMG_W-1, IMG_H-1).
- Output count per frame is exactly (IMG_W-2)·(IMG_H-2).

## Timing
- Reset (rst_n=0 at an edge):
  - `valid_out`=0, `eof_out`=0, `p0..p8`=0.
  - col=0, row=0, state=FILL.
  - Reset overrides `pix_valid` in the same cycle, and that pixel is dropped.
- Latency: one cycle. The pixel accepted at edge k appears as `p8` after edge k, with `valid_out` high for the cycle that follows.
- `valid_out` and `eof_out` are single-cycle pulses, high only in cycles following an accept.
- `pix_valid`=0 ⇒ `valid_out`=0, `eof_out`=0, and `p0..p8` hold their values. Gaps of any length are legal.
- Windows never straddle lines. At col 0 and col 1 of each row the shift still occurs, but `valid_out` stays 0.
- Sustained throughput is one window per clock.

## Structure
- `sobel_pkg`: `PIX_W`=8 and the FSM state typedef (FILL, STREAM), shared with the gradient stage.
- Sub-module `sobel_line_buffer` (parameter DEPTH=IMG_W, width PIX_W): async read, sync write. Instantiated twice.
- The top level holds the counters, FSM, window registers and output flags.

## Test plan
All scenarios use IMG_W=5, IMG_H=4 and pixel value = row·16 + col.
- Frame 0, contiguous:
  - First `valid_out` comes one cycle after the 13th accept, pixel (2,2). p0..p8 = 00,01,02,10,11,12,20,21,22.
  - There are exactly 6 windows, none asserted at col 0 or col 1.
- Last window: p0..p8 = 12,13,14,22,23,24,32,33,34, with `eof_out`=1 in the same cycle only.
- Random `pix_valid` gaps (30% idle): the window sequence is identical to the contiguous run, and outputs hold during gaps.
- `pix_sof` asserted at pixel (2,3) of frame 0, then a full frame follows: no further frame-0 windows. The next frame's first window is again 00..22, after 13 accepts.
- `rst_n` low for 1 cycle mid-STREAM: the following cycle shows all outputs 0. The restarted frame then yields 6 correct windows.
- Two back-to-back frames with no `pix_sof`: 12 windows and two `eof_out` pulses, with the second frame's first window equal to 00..22.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pipeline: pixel width and window-generator FSM states.
package sobel_pkg;

    localparam int PIX_W = 8;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } sobel_state_e;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage: asynchronous read, synchronous write, contents never reset.
module sobel_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read returns the pre-write word, so the same address reads the older row and stores the newer one.
    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-scan 3x3 window generator feeding the Sobel gradient stage; one window per accepted
// interior pixel, two line buffers holding rows r-1 and r-2.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_in,
    output logic             valid_out,
    output logic             eof_out,
    output logic [PIX_W-1:0] p0,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p4,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    logic [CW-1:0]    col_q, col_d, col_eff;
    logic [RW-1:0]    row_q, row_d, row_eff;
    sobel_state_e     state_q;
    logic             valid_q, eof_q;
    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] lb_a_rd, lb_b_rd;
    logic             at_last_col, at_last_row;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    always_comb begin
        col_eff     = pix_sof ? '0 : col_q;
        row_eff     = pix_sof ? '0 : row_q;
        at_last_col = (col_eff == COL_LAST);
        at_last_row = (row_eff == ROW_LAST);
        col_d       = at_last_col ? '0 : col_eff + CW'(1);
        row_d       = row_eff;
        if (at_last_col) begin
            row_d = at_last_row ? '0 : row_eff + RW'(1);
        end
    end

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_a (
        .clk     (clk),
        .we_i    (pix_valid),
        .addr_i  (col_eff),
        .wdata_i (pix_in),
        .rdata_o (lb_a_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_b (
        .clk     (clk),
        .we_i    (pix_valid),
        .addr_i  (col_eff),
        .wdata_i (lb_a_rd),
        .rdata_o (lb_b_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            state_q <= FILL;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
            if (pix_valid) begin
                col_q <= col_d;
                row_q <= row_d;
                for (int r = 0; r < 3; r++) begin
                    win_q[3*r]   <= win_q[3*r+1];
                    win_q[3*r+1] <= win_q[3*r+2];
                end
                win_q[2] <= lb_b_rd;
                win_q[5] <= lb_a_rd;
                win_q[8] <= pix_in;
                case (state_q)
                    FILL: begin
                        if (at_last_col && row_eff == ROW_ONE) begin
                            state_q <= STREAM;
                        end
                    end
                    STREAM: begin
                        // Columns 0 and 1 would straddle the previous line, so no window there.
                        valid_q <= (col_eff >= COL_TWO);
                        eof_q   <= at_last_col && at_last_row;
                        if (pix_sof || (at_last_col && at_last_row)) begin
                            state_q <= FILL;
                        end
                    end
                    default: state_q <= FILL;
                endcase
            end
        end
    end

    assign valid_out = valid_q;
    assign eof_out   = eof_q;
    assign p0 = win_q[0];
    assign p1 = win_q[1];
    assign p2 = win_q[2];
    assign p3 = win_q[3];
    assign p4 = win_q[4];
    assign p5 = win_q[5];
    assign p6 = win_q[6];
    assign p7 = win_q[7];
    assign p8 = win_q[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed/random bench for sobel_window_gen against an image-array reference model.
module tb_sobel_window_gen;

    localparam int W = 5;
    localparam int H = 4;
    localparam logic [71:0] WIN_FIRST = 72'h00_01_02_10_11_12_20_21_22;
    localparam logic [71:0] WIN_LAST  = 72'h12_13_14_22_23_24_32_33_34;

    logic       clk = 1'b0;
    logic       rst_n, pix_valid, pix_sof;
    logic [7:0] pix_in;
    logic       valid_out, eof_out;
    logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    wire [71:0] p_all = {p0, p1, p2, p3, p4, p5, p6, p7, p8};

    sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_in(pix_in),
        .valid_out(valid_out), .eof_out(eof_out),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the image as written so far plus the raster position of the next pixel.
    logic [7:0]  img [H][W];
    int          mcol, mrow;
    int          win_cnt, eof_cnt, acc_cnt, first_acc;
    logic [71:0] first_win, last_win, prev_p;
    logic [71:0] win_list[$];
    logic [71:0] ref_list[$];

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        win_cnt = 0; eof_cnt = 0; acc_cnt = 0; first_acc = 0;
        first_win = '0; last_win = '0;
        win_list.delete();
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] px);
        int r, c;
        logic exp_v, exp_eof;
        logic [71:0] ew;
        rst_n = 1'b1; pix_valid = v; pix_sof = s; pix_in = px;
        exp_v = 1'b0; exp_eof = 1'b0; ew = '0; r = 0; c = 0;
        if (v) begin
            if (s) begin r = 0; c = 0; end else begin r = mrow; c = mcol; end
            img[r][c] = px;
            exp_v   = (r >= 2) && (c >= 2);
            exp_eof = exp_v && (r == H-1) && (c == W-1);
            if (exp_v)
                ew = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                      img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                      img[r][c-2],   img[r][c-1],   img[r][c]};
            mcol = c + 1; mrow = r;
            if (mcol == W) begin mcol = 0; mrow = (r + 1) % H; end
            acc_cnt++;
        end
        @(posedge clk); #1;
        check("valid_out", {71'b0, valid_out}, {71'b0, exp_v});
        check("eof_out", {71'b0, eof_out}, {71'b0, exp_eof});
        if (eof_out === 1'b1) eof_cnt++;
        if (exp_v) begin
            check("window", p_all, ew);
            win_cnt++;
            win_list.push_back(p_all);
            if (win_cnt == 1) begin first_win = p_all; first_acc = acc_cnt; end
            last_win = p_all;
        end else if (v) begin
            check("p8_newest", {64'b0, p8}, {64'b0, px});
        end else begin
            check("hold_in_gap", p_all, prev_p);
        end
        prev_p = p_all;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pix_valid = 1'b1; pix_sof = 1'b0; pix_in = 8'($urandom);
        @(posedge clk); #1;
        check("reset_valid", {71'b0, valid_out}, 72'b0);
        check("reset_eof", {71'b0, eof_out}, 72'b0);
        check("reset_window", p_all, 72'b0);
        mcol = 0; mrow = 0; prev_p = '0;
    endtask

    task automatic send_frame(input bit rnd, input int gap_pct, input bit sof);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                while ($urandom_range(99) < gap_pct)
                    step(1'b0, 1'($urandom_range(1)), 8'($urandom));
                step(1'b1, sof && r == 0 && c == 0, rnd ? 8'($urandom) : 8'(r*16 + c));
            end
    endtask

    task automatic feed(input int n, input bit rnd);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, rnd ? 8'($urandom) : 8'(mrow*16 + mcol));
    endtask

    initial begin
        rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0;
        mcol = 0; mrow = 0; prev_p = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = '0;
        @(negedge clk);
        do_reset();

        // contiguous frame
        clear_stats();
        send_frame(1'b0, 0, 1'b0);
        check("f0_first_acc", 72'(first_acc), 72'd13);
        check("f0_first_win", first_win, WIN_FIRST);
        check("f0_count", 72'(win_cnt), 72'd6);
        check("f0_last_win", last_win, WIN_LAST);
        check("f0_eofs", 72'(eof_cnt), 72'd1);
        ref_list = win_list;

        // same frame with random idle cycles
        clear_stats();
        send_frame(1'b0, 30, 1'b0);
        check("gap_count", 72'(win_cnt), 72'd6);
        for (int i = 0; i < ref_list.size(); i++)
            if (i < win_list.size()) check("gap_sequence", win_list[i], ref_list[i]);
        check("gap_eofs", 72'(eof_cnt), 72'd1);

        // abandon a frame at (col 2, row 3) with a new start of frame
        feed(3*W + 2, 1'b1);
        clear_stats();
        send_frame(1'b0, 0, 1'b1);
        check("sof_count", 72'(win_cnt), 72'd6);
        check("sof_first_acc", 72'(first_acc), 72'd13);
        check("sof_first_win", first_win, WIN_FIRST);
        check("sof_eofs", 72'(eof_cnt), 72'd1);

        // reset in the middle of streaming, then a random frame
        feed(2*W + 3, 1'b1);
        do_reset();
        clear_stats();
        send_frame(1'b1, 20, 1'b0);
        check("rst_count", 72'(win_cnt), 72'd6);
        check("rst_eofs", 72'(eof_cnt), 72'd1);

        // two back-to-back frames without start of frame
        clear_stats();
        send_frame(1'b0, 0, 1'b0);
        send_frame(1'b0, 10, 1'b0);
        check("b2b_count", 72'(win_cnt), 72'd12);
        check("b2b_eofs", 72'(eof_cnt), 72'd2);
        if (win_list.size() > 6) check("b2b_second_first", win_list[6], WIN_FIRST);
        check("b2b_last_win", last_win, WIN_LAST);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
